max_pool2: RTL and testbench
============================

MAX_POOL2 -- requirements
Module: max_pool2

Interface
REQ-001 Parameter DATA_W, default 32: pixel word width, matching the convolution stage output word.
REQ-002 Parameter IMG_W, default 26: pixels per input row; even, 4..1022.
REQ-003 Parameter IMG_H, default 26: rows per input frame; even, 4..1022.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset; low clears all state immediately.
REQ-006 pxl_in  input  DATA_W  signed two's-complement pixel from the convolution stage, raster order.
REQ-007 in_valid  input  1  pxl_in is a real pixel this cycle; no backpressure exists.
REQ-008 pxl_out  output  DATA_W  signed maximum of one 2x2 window.
REQ-009 out_valid  output  1  one-cycle pulse per pooled pixel.
REQ-010 out_count  output  10  pooled pixels emitted in the current frame; increments with each out_valid.
REQ-011 frame_done  output  1  one-cycle pulse coincident with the last out_valid of a frame.

Function
REQ-012 Beats: only cycles with in_valid=1 advance col (0..IMG_W-1) and row (0..IMG_H-1); in_valid=0 cycles hold all state, any number, anywhere.
REQ-013 FSM states EVEN_ROW and ODD_ROW; reset enters EVEN_ROW; the beat with col=IMG_W-1 toggles the state; the last beat of ODD_ROW with row=IMG_H-1 returns to EVEN_ROW with row=0.
REQ-014 Even col beat (both states): pxl_in is held in pair register hold.
REQ-015 EVEN_ROW, odd col beat: signed max(hold, pxl_in) is written to line buffer entry col/2.
REQ-016 ODD_ROW, odd col beat: signed max(hold, pxl_in, buffer[col/2]) is registered to pxl_out.
REQ-017 That beat also drives out_valid=1 on the next cycle; latency is exactly 1 clock from the completing beat.
REQ-018 Comparison is signed over full DATA_W; no truncation, no saturation; on ties either operand is acceptable (same value).
REQ-019 pxl_out holds its last value while out_valid=0.
REQ-020 Each frame emits exactly (IMG_W/2)*(IMG_H/2) outputs; out_count runs 1..N, returns to 0 on the first beat of the next frame, and wraps modulo 1024.
REQ-021 frame_done=1 with the out_valid of the window at row=IMG_H-1, col=IMG_W-1.
REQ-022 Back-to-back frames with no idle cycle between them are accepted with no lost or duplicated output.

Reset
REQ-023 While reset=0: pxl_out=0, out_valid=0, out_count=0, frame_done=0, col=0, row=0, hold=0, state=EVEN_ROW.
REQ-024 Line buffer contents are not reset; they are always written in EVEN_ROW before being read in ODD_ROW.
REQ-025 Reset asserted mid-frame discards the partial frame; the first beat after release is treated as row 0, col 0.

Structure
REQ-026 Shared package pool_pkg holds DATA_W, IMG_W and IMG_H defaults and the state encoding.
REQ-027 The line buffer is sub-module pool_linebuf, an IMG_W/2 x DATA_W register array with one write port and one combinational read port.
REQ-028 Counters, FSM and comparators live in max_pool2; the target is 120-400 lines of RTL total.

Verification
REQ-029 IMG_W=IMG_H=4, input rows 1..4, 5..8, 9..12, 13..16, in_valid continuous -> pxl_out 6, 8, 14, 16; out_count 1..4; frame_done with 16.
REQ-030 Same geometry, all inputs negative (-16..-1 ascending) -> pxl_out -11, -9, -3, -1, using signed comparison.
REQ-031 The REQ-029 frame with in_valid low for 3 cycles after every second beat -> identical output values; each output 1 cycle after its completing beat.
REQ-032 Reset pulsed low after beat 9 of the REQ-029 frame, then the full frame resent -> outputs low during reset; afterwards exactly 6, 8, 14, 16.
REQ-033 Two REQ-029 frames back-to-back, the second with every value +100 -> 6, 8, 14, 16, 106, 108, 114, 116; out_count returns to 1 for 106; two frame_done pulses.
REQ-034 Default 26x26, random signed 32-bit stimulus -> 169 outputs matching a reference 2x2 max model; out_count ends at 169.

Source files
------------

// File: rtl/pool_pkg.sv
// Shared defaults and FSM encoding for the 2x2 max-pooling stage.
package pool_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_IMG_W  = 26;
  localparam int DEF_IMG_H  = 26;
  localparam int OUT_CNT_W  = 10;

  localparam logic [0:0] ST_EVEN_ROW = 1'b0;
  localparam logic [0:0] ST_ODD_ROW  = 1'b1;

endpackage

// File: rtl/pool_linebuf.sv
// Half-row line buffer: one synchronous write port, one combinational read port.
module pool_linebuf
  import pool_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_IMG_W / 2,
  parameter int ADDR_W = $clog2(DEF_IMG_W) - 1
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  // No reset: every entry is written on the even row before the odd row reads it.
  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/max_pool2.sv
// 2x2 stride-2 signed max pooling over a raster-order pixel stream, no backpressure.
module max_pool2
  import pool_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int IMG_W  = DEF_IMG_W,
  parameter int IMG_H  = DEF_IMG_H
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] pxl_in,
  input  logic              in_valid,
  output logic [DATA_W-1:0] pxl_out,
  output logic              out_valid,
  output logic [9:0]        out_count,
  output logic              frame_done
);

  localparam int COL_W    = $clog2(IMG_W);
  localparam int ROW_W    = $clog2(IMG_H);
  localparam int LB_AW    = COL_W - 1;
  localparam int LB_DEPTH = IMG_W / 2;

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

  function automatic logic [DATA_W-1:0] smax(input logic [DATA_W-1:0] a,
                                             input logic [DATA_W-1:0] b);
    return ($signed(a) > $signed(b)) ? a : b;
  endfunction

  logic [0:0]           r_state;
  logic [COL_W-1:0]     r_col;
  logic [ROW_W-1:0]     r_row;
  logic [DATA_W-1:0]    r_hold;
  logic [DATA_W-1:0]    r_pxl_out;
  logic                 r_out_valid;
  logic [OUT_CNT_W-1:0] r_out_count;
  logic                 r_frame_done;

  logic              w_col_last;
  logic              w_row_last;
  logic              w_lb_we;
  logic              w_emit;
  logic              w_frame_start;
  logic [DATA_W-1:0] w_pair_max;
  logic [DATA_W-1:0] w_lb_rdata;
  logic [DATA_W-1:0] w_win_max;

  assign w_col_last    = (r_col == COL_LAST);
  assign w_row_last    = (r_row == ROW_LAST);
  assign w_lb_we       = in_valid && (r_state == ST_EVEN_ROW) && r_col[0];
  assign w_emit        = in_valid && (r_state == ST_ODD_ROW) && r_col[0];
  assign w_frame_start = in_valid && (r_state == ST_EVEN_ROW) && (r_row == '0) && (r_col == '0);
  assign w_pair_max    = smax(r_hold, pxl_in);
  assign w_win_max     = smax(w_pair_max, w_lb_rdata);

  pool_linebuf #(
    .DATA_W (DATA_W),
    .DEPTH  (LB_DEPTH),
    .ADDR_W (LB_AW)
  ) u_linebuf (
    .i_clk   (clk),
    .i_we    (w_lb_we),
    .i_waddr (r_col[COL_W-1:1]),
    .i_wdata (w_pair_max),
    .i_raddr (r_col[COL_W-1:1]),
    .o_rdata (w_lb_rdata)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_EVEN_ROW;
      r_col        <= '0;
      r_row        <= '0;
      r_hold       <= '0;
      r_pxl_out    <= '0;
      r_out_valid  <= 1'b0;
      r_out_count  <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_out_valid  <= w_emit;
      r_frame_done <= w_emit && w_col_last && w_row_last;

      // Count clears on the first beat of a frame, which can never also emit.
      if (w_emit) begin
        r_pxl_out   <= w_win_max;
        r_out_count <= r_out_count + OUT_CNT_W'(1);
      end else if (w_frame_start) begin
        r_out_count <= '0;
      end

      if (in_valid) begin
        if (!r_col[0]) begin
          r_hold <= pxl_in;
        end
        if (w_col_last) begin
          r_col   <= '0;
          r_state <= (r_state == ST_EVEN_ROW) ? ST_ODD_ROW : ST_EVEN_ROW;
          r_row   <= w_row_last ? '0 : r_row + ROW_W'(1);
        end else begin
          r_col <= r_col + COL_W'(1);
        end
      end
    end
  end

  assign pxl_out    = r_pxl_out;
  assign out_valid  = r_out_valid;
  assign out_count  = r_out_count;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_max_pool2.sv
// Scoreboard bench for max_pool2: a 4x4 instance for directed frames, a 26x26 one for random.
module tb_max_pool2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [31:0] pin4, pin26;
  logic        v4, v26;
  logic [31:0] pout4, pout26;
  logic        ov4, ov26;
  logic [9:0]  cnt4, cnt26;
  logic        fd4, fd26;

  max_pool2 #(.DATA_W(32), .IMG_W(4), .IMG_H(4)) dut4 (
    .clk        (clk),
    .reset      (reset),
    .pxl_in     (pin4),
    .in_valid   (v4),
    .pxl_out    (pout4),
    .out_valid  (ov4),
    .out_count  (cnt4),
    .frame_done (fd4)
  );

  max_pool2 dut26 (
    .clk        (clk),
    .reset      (reset),
    .pxl_in     (pin26),
    .in_valid   (v26),
    .pxl_out    (pout26),
    .out_valid  (ov26),
    .out_count  (cnt26),
    .frame_done (fd26)
  );

  typedef struct packed {
    logic [31:0] px;
    logic [9:0]  cnt;
    logic        done;
    logic [31:0] cyc;
  } exp_t;

  exp_t        q4[$];
  exp_t        q26[$];
  logic [31:0] img [676];
  logic [31:0] cyc = 0;
  int          n_cmp = 0;
  int          n_err = 0;
  int          done4_pulses = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h)", tag, $signed(got), got,
               $signed(exp), exp);
    end
  endtask

  function automatic logic [31:0] smax(input logic [31:0] a, input logic [31:0] b);
    return ($signed(a) > $signed(b)) ? a : b;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      v4  = 1'b0;
      v26 = 1'b0;
    end
  endtask

  // Drives one frame from img (plus offs); pushes each window's expectation as its last beat goes out.
  task automatic send(input int which, input int w, input int h, input int gap,
                      input int stop_after, input logic [31:0] offs);
    exp_t        e;
    logic [31:0] v;
    int          idx;
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        idx = r * w + c;
        if (stop_after > 0 && idx >= stop_after) return;
        @(posedge clk);
        #1;
        v = img[idx] + offs;
        if (which == 0) begin
          v4 = 1'b1;
          pin4 = v;
        end else begin
          v26 = 1'b1;
          pin26 = v;
        end
        if ((r % 2 == 1) && (c % 2 == 1)) begin
          e.px   = smax(smax(img[(r-1)*w+c-1], img[(r-1)*w+c]), smax(img[r*w+c-1], img[idx]))
                   + offs;
          e.cnt  = 10'((r / 2) * (w / 2) + c / 2 + 1);
          e.done = (r == h - 1) && (c == w - 1);
          e.cyc  = cyc + 1;
          if (which == 0) q4.push_back(e);
          else q26.push_back(e);
        end
        if (gap != 0 && (idx % 2 == 1)) begin
          idle(3);
          if (which == 0 && idx == 1) check_eq("cnt_clear_on_frame_start", 32'(cnt4), 0);
        end
      end
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      if (ov4) begin
        check_eq("p4_output_expected", 32'(q4.size() > 0), 1);
        if (q4.size() > 0) begin
          e = q4.pop_front();
          check_eq("p4_pxl_out", pout4, e.px);
          check_eq("p4_out_count", 32'(cnt4), 32'(e.cnt));
          check_eq("p4_frame_done", 32'(fd4), 32'(e.done));
          check_eq("p4_latency_cycle", cyc, e.cyc);
        end
      end
      if (fd4) begin
        done4_pulses++;
        check_eq("p4_done_with_valid", 32'(ov4), 1);
      end
      if (ov26) begin
        check_eq("p26_output_expected", 32'(q26.size() > 0), 1);
        if (q26.size() > 0) begin
          e = q26.pop_front();
          check_eq("p26_pxl_out", pout26, e.px);
          check_eq("p26_out_count", 32'(cnt26), 32'(e.cnt));
          check_eq("p26_frame_done", 32'(fd26), 32'(e.done));
          check_eq("p26_latency_cycle", cyc, e.cyc);
        end
      end
      if (fd26) check_eq("p26_done_with_valid", 32'(ov26), 1);
    end
  end

  initial begin
    reset = 1'b0;
    v4 = 1'b0;
    v26 = 1'b0;
    pin4 = '0;
    pin26 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_pxl_out", pout4, 0);
    check_eq("rst_out_valid", 32'(ov4), 0);
    check_eq("rst_out_count", 32'(cnt4), 0);
    check_eq("rst_frame_done", 32'(fd4), 0);
    check_eq("rst26_out_count", 32'(cnt26), 0);
    @(posedge clk);
    #1 reset = 1'b1;

    // Ascending positive frame.
    for (int i = 0; i < 16; i++) img[i] = 32'(i + 1);
    send(0, 4, 4, 0, 0, 0);
    idle(3);
    check_eq("hold_pxl_out", pout4, 16);
    check_eq("hold_out_count", 32'(cnt4), 4);
    check_eq("done_pulses_frame1", 32'(done4_pulses), 1);

    // All-negative frame exercises signed comparison.
    for (int i = 0; i < 16; i++) img[i] = 32'(-16 + i);
    send(0, 4, 4, 0, 0, 0);
    idle(3);
    check_eq("neg_last_pxl", pout4, 32'(-1));

    // Same positive frame with 3 idle cycles after every second beat.
    for (int i = 0; i < 16; i++) img[i] = 32'(i + 1);
    check_eq("cnt_before_gap_frame", 32'(cnt4), 4);
    send(0, 4, 4, 1, 0, 0);
    idle(3);

    // Reset after beat 9, then the full frame again.
    send(0, 4, 4, 0, 9, 0);
    idle(2);
    reset = 1'b0;
    @(negedge clk);
    check_eq("midrst_pxl_out", pout4, 0);
    check_eq("midrst_out_valid", 32'(ov4), 0);
    check_eq("midrst_out_count", 32'(cnt4), 0);
    check_eq("midrst_frame_done", 32'(fd4), 0);
    @(posedge clk);
    #1 reset = 1'b1;
    send(0, 4, 4, 0, 0, 0);
    idle(3);

    // Back-to-back frames, second offset by +100.
    done4_pulses = 0;
    send(0, 4, 4, 0, 0, 0);
    send(0, 4, 4, 0, 0, 100);
    idle(3);
    check_eq("b2b_done_pulses", 32'(done4_pulses), 2);
    check_eq("b2b_last_pxl", pout4, 116);

    // Default geometry with random signed data.
    for (int i = 0; i < 676; i++) img[i] = $urandom;
    send(1, 26, 26, 0, 0, 0);
    idle(3);
    check_eq("rand_final_count", 32'(cnt26), 169);

    check_eq("drain_q4", 32'(q4.size()), 0);
    check_eq("drain_q26", 32'(q26.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
